// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel synchroniser, debouncer and hold classifier
// (press / release / long / auto-repeat) with a press-driven toggle bit.
//
// Hold FSM states (one FSM per channel):
//   state   | meaning
//   IDLE    | key released, hold counter parked at 0
//   HOLD    | key pressed, counting towards the long-press threshold
//   LONG    | long press reached, counting auto-repeat periods
module key_debounce_multi #(
  parameter int CLK_FREQ    = 100000000,
  parameter int NUM_KEYS    = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [NUM_KEYS-1:0] key_long_o,
  output logic [NUM_KEYS-1:0] key_repeat_o,
  output logic [NUM_KEYS-1:0] key_toggle_o
);

  localparam int unsigned MS_CYC   = CLK_FREQ / 1000;
  localparam int unsigned DB_CYC   = MS_CYC * DEBOUNCE_MS;
  localparam int unsigned LONG_CYC = MS_CYC * LONG_MS;
  localparam int unsigned REP_CYC  = MS_CYC * REPEAT_MS;
  localparam int unsigned MAX_A    = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
  localparam int unsigned MAX_CYC  = (MAX_A > REP_CYC) ? MAX_A : REP_CYC;
  localparam int          CW       = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DB_TC   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYC - 1);
  // Guarded so a disabled repeat does not underflow the terminal count.
  localparam logic [CW-1:0] REP_TC  = CW'((REP_CYC > 0) ? REP_CYC - 1 : 0);
  localparam bit            REP_EN  = (REPEAT_MS != 0);
  // Raw level of a released key; XOR with it normalises to 1 = pressed.
  localparam logic          REL_LVL = (ACTIVE_LOW != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic          sync1_q, sync2_q, s;
    logic          accept;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          toggle_q, toggle_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    fsm_q, fsm_d;

    // Two-flop synchroniser, parked at the released level so reset never looks like a press.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync1_q <= REL_LVL;
        sync2_q <= REL_LVL;
      end else begin
        sync1_q <= key_i[g];
        sync2_q <= sync1_q;
      end
    end

    assign s = sync2_q ^ REL_LVL;

    // Debounce: count consecutive cycles of disagreement, accept on the terminal count.
    always_comb begin
      accept    = (s != state_q) && (db_cnt_q == DB_TC);
      db_cnt_d  = db_cnt_q + CW'(1);
      if ((s == state_q) || accept) db_cnt_d = '0;
      state_d   = accept ? s : state_q;
      press_d   = accept & s;
      release_d = accept & ~s;
      toggle_d  = toggle_q ^ press_d;
    end

    // Hold classifier; a release always wins over a coincident long/repeat wrap.
    always_comb begin
      fsm_d      = fsm_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      if (release_d) begin
        fsm_d      = ST_IDLE;
        hold_cnt_d = '0;
      end else begin
        case (fsm_q)
          ST_IDLE: begin
            if (press_d) begin
              fsm_d      = ST_HOLD;
              hold_cnt_d = '0;
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q == LONG_TC) begin
              long_d     = 1'b1;
              fsm_d      = ST_LONG;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + CW'(1);
            end
          end
          ST_LONG: begin
            if (REP_EN) begin
              if (hold_cnt_q == REP_TC) begin
                repeat_d   = 1'b1;
                hold_cnt_d = '0;
              end else begin
                hold_cnt_d = hold_cnt_q + CW'(1);
              end
            end
          end
          default: begin
            fsm_d      = ST_IDLE;
            hold_cnt_d = '0;
          end
        endcase
      end
    end

    // Channel state and registered event pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
        toggle_q   <= 1'b0;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        fsm_q      <= ST_IDLE;
      end else begin
        state_q    <= state_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
        repeat_q   <= repeat_d;
        toggle_q   <= toggle_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        fsm_q      <= fsm_d;
      end
    end

    assign key_state_o[g]   = state_q;
    assign key_press_o[g]   = press_q;
    assign key_release_o[g] = release_q;
    assign key_long_o[g]    = long_q;
    assign key_repeat_o[g]  = repeat_q;
    assign key_toggle_o[g]  = toggle_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: expected events are queued with
// their cycle number, a negedge monitor pops one per observed pulse.
module tb_key_debounce_multi;

  localparam int DB_LAT   = 2002;
  localparam int LONG_CYC = 10000;
  localparam int REP_CYC  = 3000;
  localparam int K_PRESS  = 0;
  localparam int K_REL    = 1;
  localparam int K_LONG   = 2;
  localparam int K_REP    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] key_state, key_press, key_release, key_long, key_repeat, key_toggle;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c0;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;
  ev_t exp_q[$];

  key_debounce_multi #(
    .CLK_FREQ(1000000), .NUM_KEYS(4), .DEBOUNCE_MS(2),
    .LONG_MS(10), .REPEAT_MS(3), .ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key),
    .key_state_o(key_state), .key_press_o(key_press),
    .key_release_o(key_release), .key_long_o(key_long),
    .key_repeat_o(key_repeat), .key_toggle_o(key_toggle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(input int c, input int ch, input int k);
    ev_t e;
    e.cyc = c;
    e.ch = ch;
    e.kind = k;
    exp_q.push_back(e);
  endfunction

  function automatic logic pulse_of(input int k, input int ch);
    case (k)
      K_PRESS: return key_press[ch];
      K_REL:   return key_release[ch];
      K_LONG:  return key_long[ch];
      default: return key_repeat[ch];
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int all_outputs();
    return int'({key_state, key_press, key_release, key_long, key_repeat, key_toggle});
  endfunction

  // Monitor: every pulse seen must match the head of the expected-event queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int k = 0; k < 4; k++) begin
          if (pulse_of(k, ch)) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_event: ch %0d kind %0d at cycle %0d, none required", ch, k, cyc);
            end else begin
              e = exp_q.pop_front();
              if (e.cyc != cyc || e.ch != ch || e.kind != k) begin
                errors++;
                $display("FAIL event: actual ch %0d kind %0d cycle %0d, required ch %0d kind %0d cycle %0d",
                         ch, k, cyc, e.ch, e.kind, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    key = 4'hF;
    rst_n = 1'b0;
    wait_n(3);
    chk("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    wait_n(5);

    // Clean press and release on key 0
    c0 = cyc; key[0] = 1'b0;
    expect_ev(c0 + DB_LAT, 0, K_PRESS);
    wait_n(DB_LAT - 1);
    chk("press0_state_early", int'(key_state[0]), 0);
    wait_n(1);
    chk("press0_state", int'(key_state[0]), 1);
    chk("press0_toggle", int'(key_toggle[0]), 1);
    wait_n(100);
    c0 = cyc; key[0] = 1'b1;
    expect_ev(c0 + DB_LAT, 0, K_REL);
    wait_n(DB_LAT + 5);
    chk("rel0_state", int'(key_state[0]), 0);
    chk("rel0_toggle", int'(key_toggle[0]), 1);

    // Chatter on key 1 shorter than the debounce window, then a steady press
    for (int i = 0; i < 3; i++) begin
      key[1] = 1'b0; wait_n(1500);
      key[1] = 1'b1; wait_n(1500);
    end
    wait_n(1000);
    chk("bounce_state", int'(key_state[1]), 0);
    c0 = cyc; key[1] = 1'b0;
    expect_ev(c0 + DB_LAT, 1, K_PRESS);
    wait_n(DB_LAT + 500);
    c0 = cyc; key[1] = 1'b1;
    expect_ev(c0 + DB_LAT, 1, K_REL);
    wait_n(DB_LAT + 5);

    // Long press with auto-repeat on key 2, held 20000 cycles
    c0 = cyc; key[2] = 1'b0;
    expect_ev(c0 + DB_LAT, 2, K_PRESS);
    expect_ev(c0 + DB_LAT + LONG_CYC, 2, K_LONG);
    expect_ev(c0 + DB_LAT + LONG_CYC + REP_CYC, 2, K_REP);
    expect_ev(c0 + DB_LAT + LONG_CYC + 2 * REP_CYC, 2, K_REP);
    expect_ev(c0 + DB_LAT + LONG_CYC + 3 * REP_CYC, 2, K_REP);
    wait_n(DB_LAT + LONG_CYC + 10);
    chk("long2_state", int'(key_state[2]), 1);
    wait_n(20000 - DB_LAT - LONG_CYC - 10);
    key[2] = 1'b1;
    expect_ev(c0 + 20000 + DB_LAT, 2, K_REL);
    wait_n(DB_LAT + 5);

    // Key 3: release pulse lands on the first repeat wrap edge and must win
    c0 = cyc; key[3] = 1'b0;
    expect_ev(c0 + DB_LAT, 3, K_PRESS);
    expect_ev(c0 + DB_LAT + LONG_CYC, 3, K_LONG);
    wait_n(13000);
    key[3] = 1'b1;
    expect_ev(c0 + 13000 + DB_LAT, 3, K_REL);
    wait_n(DB_LAT + 500);

    // Short reset to clear the toggles before the parallel test
    rst_n = 1'b0;
    wait_n(2);
    chk("reset2_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    wait_n(5);

    // Parallel press on keys 0 and 3
    c0 = cyc; key[0] = 1'b0; key[3] = 1'b0;
    expect_ev(c0 + DB_LAT, 0, K_PRESS);
    expect_ev(c0 + DB_LAT, 3, K_PRESS);
    wait_n(DB_LAT);
    chk("par_state", int'(key_state), 4'b1001);
    chk("par_toggle", int'(key_toggle), 4'b1001);
    wait_n(10);
    c0 = cyc; key[0] = 1'b1; key[3] = 1'b1;
    expect_ev(c0 + DB_LAT, 0, K_REL);
    expect_ev(c0 + DB_LAT, 3, K_REL);
    wait_n(DB_LAT + 5);
    c0 = cyc; key[0] = 1'b0;
    expect_ev(c0 + DB_LAT, 0, K_PRESS);
    wait_n(DB_LAT + 10);
    c0 = cyc; key[0] = 1'b1;
    expect_ev(c0 + DB_LAT, 0, K_REL);
    wait_n(DB_LAT + 5);
    chk("par_toggle2", int'(key_toggle), 4'b1000);

    // Reset 5000 cycles into a hold on key 0, key kept low through reset
    c0 = cyc; key[0] = 1'b0;
    expect_ev(c0 + DB_LAT, 0, K_PRESS);
    wait_n(DB_LAT + 5000);
    chk("hold_pre_reset", int'({key_state, key_toggle}), 8'h19);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_hold", all_outputs(), 0);
    wait_n(3);
    rst_n = 1'b1;
    c0 = cyc;
    expect_ev(c0 + DB_LAT, 0, K_PRESS);
    expect_ev(c0 + DB_LAT + LONG_CYC, 0, K_LONG);
    wait_n(DB_LAT + LONG_CYC);
    key[0] = 1'b1;
    expect_ev(cyc + DB_LAT, 0, K_REL);
    wait_n(DB_LAT + 10);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
